// File: rtl/registro_temp.sv
// Temperature sample register: valid/ready intake, 2^PROM_LOG2 moving average,
// out-of-range persistence counter and silent-sensor timeout.
module registro_temp #(
  parameter int TEMP_BAJO    = 180,
  parameter int TEMP_ALTO    = 259,
  parameter int TEMP_INICIAL = 220,
  parameter int PROM_LOG2    = 2,
  parameter int TIMEOUT      = 1000
) (
  input  logic               clk,
  input  logic               arst,
  input  logic signed [10:0] temp_in,
  input  logic               temp_valid,
  output logic               temp_ready,
  output logic signed [10:0] temp_registrado,
  output logic [2:0]         contador_fuera_rango,
  output logic               dato_nuevo,
  output logic               falla_sensor
);

  localparam int W  = 1 << PROM_LOG2;
  localparam int SW = 11 + PROM_LOG2;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic signed [10:0] BAJO = 11'(TEMP_BAJO);
  localparam logic signed [10:0] ALTO = 11'(TEMP_ALTO);

  typedef enum logic [1:0] {LLENADO, OPERA, PUBLICA, FALLA} estado_t;

  estado_t                estado_q, estado_d;
  logic signed [10:0]     win_q [W];
  logic signed [10:0]     win_d [W];
  logic [PROM_LOG2-1:0]   ptr_q, ptr_d;
  logic signed [SW-1:0]   sum_q, sum_d;
  logic [PROM_LOG2:0]     fill_q, fill_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic signed [10:0]     temp_q, temp_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   lado_q, lado_d;   // 1 = last excursion was high
  logic                   dato_q, dato_d;

  logic                   acepta;
  logic signed [10:0]     avg;
  logic                   fuera_bajo, fuera_alto;

  assign temp_ready = (estado_q != PUBLICA);
  assign acepta     = temp_valid && temp_ready;
  assign avg        = 11'(sum_q >>> PROM_LOG2);
  assign fuera_bajo = (avg < BAJO);
  assign fuera_alto = (avg > ALTO);

  always_comb begin
    estado_d = estado_q;
    win_d    = win_q;
    ptr_d    = ptr_q;
    sum_d    = sum_q;
    fill_d   = fill_q;
    timer_d  = timer_q;
    temp_d   = temp_q;
    cnt_d    = cnt_q;
    lado_d   = lado_q;
    dato_d   = 1'b0;
    unique case (estado_q)
      LLENADO, OPERA: begin
        if (acepta) begin
          sum_d        = sum_q + SW'(temp_in) - SW'(win_q[ptr_q]);
          win_d[ptr_q] = temp_in;
          ptr_d        = ptr_q + PROM_LOG2'(1);
          timer_d      = '0;
          if (estado_q == OPERA) begin
            estado_d = PUBLICA;
          end else begin
            fill_d = fill_q + (PROM_LOG2 + 1)'(1);
            if (fill_q == (PROM_LOG2 + 1)'(W - 1)) estado_d = PUBLICA;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // accept takes priority over expiry on the same edge
          estado_d = FALLA;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PUBLICA: begin
        temp_d   = avg;
        dato_d   = 1'b1;
        estado_d = OPERA;
        if (!fuera_bajo && !fuera_alto) begin
          cnt_d = '0;
        end else begin
          if (cnt_q != 3'd0 && lado_q == fuera_alto)
            cnt_d = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
          else
            cnt_d = 3'd1;
          lado_d = fuera_alto;
        end
      end
      FALLA: begin
        if (acepta) begin
          for (int unsigned i = 0; i < W; i++) win_d[i] = '0;
          win_d[0] = temp_in;
          ptr_d    = PROM_LOG2'(1);
          sum_d    = SW'(temp_in);
          fill_d   = (PROM_LOG2 + 1)'(1);
          timer_d  = '0;
          estado_d = LLENADO;
        end
      end
      default: estado_d = LLENADO;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      estado_q <= LLENADO;
      for (int unsigned i = 0; i < W; i++) win_q[i] <= '0;
      ptr_q    <= '0;
      sum_q    <= '0;
      fill_q   <= '0;
      timer_q  <= '0;
      temp_q   <= 11'(TEMP_INICIAL);
      cnt_q    <= '0;
      lado_q   <= 1'b0;
      dato_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      win_q    <= win_d;
      ptr_q    <= ptr_d;
      sum_q    <= sum_d;
      fill_q   <= fill_d;
      timer_q  <= timer_d;
      temp_q   <= temp_d;
      cnt_q    <= cnt_d;
      lado_q   <= lado_d;
      dato_q   <= dato_d;
    end
  end

  assign temp_registrado      = temp_q;
  assign contador_fuera_rango = cnt_q;
  assign dato_nuevo           = dato_q;
  assign falla_sensor         = (estado_q == FALLA);

endmodule

// File: tb/tb_registro_temp.sv
// Directed bench for registro_temp with PROM_LOG2=2 (window 4) and TIMEOUT=20.
module tb_registro_temp;

  logic               clk = 1'b0;
  logic               arst;
  logic signed [10:0] temp_in;
  logic               temp_valid;
  logic               temp_ready;
  logic signed [10:0] temp_registrado;
  logic [2:0]         contador_fuera_rango;
  logic               dato_nuevo;
  logic               falla_sensor;

  int checks   = 0;
  int failures = 0;

  registro_temp #(.TEMP_BAJO(180), .TEMP_ALTO(259), .TEMP_INICIAL(220),
                  .PROM_LOG2(2), .TIMEOUT(20)) dut (
    .clk(clk), .arst(arst), .temp_in(temp_in), .temp_valid(temp_valid),
    .temp_ready(temp_ready), .temp_registrado(temp_registrado),
    .contador_fuera_rango(contador_fuera_rango), .dato_nuevo(dato_nuevo),
    .falla_sensor(falla_sensor));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one sample and returns 1 ns after the edge that accepted it.
  task automatic send(input logic signed [10:0] v);
    int n;
    n = 0;
    temp_in    = v;
    temp_valid = 1'b1;
    while (temp_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (temp_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout got=%b exp=1", temp_ready);
    end
    tick();
    temp_valid = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; temp_valid = 1'b0; temp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    #1;
    checks++; if (temp_registrado !== 11'sd220) begin failures++; $display("FAIL reset_temp got=%0d exp=220", temp_registrado); end
    checks++; if (contador_fuera_rango !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", contador_fuera_rango); end
    checks++; if (dato_nuevo !== 1'b0) begin failures++; $display("FAIL reset_dato got=%b exp=0", dato_nuevo); end
    checks++; if (falla_sensor !== 1'b0) begin failures++; $display("FAIL reset_falla got=%b exp=0", falla_sensor); end
    checks++; if (temp_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", temp_ready); end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) begin
      send(11'sd200);
      tick();
      checks++; if (dato_nuevo !== 1'b0) begin failures++; $display("FAIL fill_early_dato sample=%0d got=%b exp=0", i + 1, dato_nuevo); end
    end
    send(11'sd200);
    checks++; if (temp_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_publica got=%b exp=0", temp_ready); end
    tick();
    checks++; if (temp_registrado !== 11'sd200) begin failures++; $display("FAIL fill_temp got=%0d exp=200", temp_registrado); end
    checks++; if (contador_fuera_rango !== 3'd0) begin failures++; $display("FAIL fill_cnt got=%0d exp=0", contador_fuera_rango); end
    checks++; if (dato_nuevo !== 1'b1) begin failures++; $display("FAIL fill_dato got=%b exp=1", dato_nuevo); end
    tick();
    checks++; if (dato_nuevo !== 1'b0) begin failures++; $display("FAIL fill_dato_pulse got=%b exp=0", dato_nuevo); end
  endtask

  task automatic test_persist();
    int ea [11] = '{225, 250, 275, 300, 300, 300, 300, 300, 300, 300, 300};
    int ec [11] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 7, 7};
    logic signed [10:0] a;
    for (int i = 0; i < 11; i++) begin
      send(11'sd300);
      tick();
      a = 11'(ea[i]);
      checks++; if (temp_registrado !== a) begin failures++; $display("FAIL persist_temp i=%0d got=%0d exp=%0d", i, temp_registrado, a); end
      checks++; if (contador_fuera_rango !== 3'(ec[i])) begin failures++; $display("FAIL persist_cnt i=%0d got=%0d exp=%0d", i, contador_fuera_rango, ec[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    send(11'sd300);
    arst = 1'b1;
    #1;
    checks++; if (temp_registrado !== 11'sd220) begin failures++; $display("FAIL mid_reset_temp got=%0d exp=220", temp_registrado); end
    checks++; if (contador_fuera_rango !== 3'd0) begin failures++; $display("FAIL mid_reset_cnt got=%0d exp=0", contador_fuera_rango); end
    checks++; if (dato_nuevo !== 1'b0) begin failures++; $display("FAIL mid_reset_dato got=%b exp=0", dato_nuevo); end
    arst = 1'b0;
    #1;
    checks++; if (temp_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", temp_ready); end
    tick();
    checks++; if (dato_nuevo !== 1'b0 || temp_registrado !== 11'sd220) begin failures++; $display("FAIL mid_reset_no_publish dato=%b temp=%0d exp dato=0 temp=220", dato_nuevo, temp_registrado); end
  endtask

  task automatic test_negatives();
    send(-11'sd1); tick();
    send(-11'sd2); tick();
    send(-11'sd2); tick();
    checks++; if (dato_nuevo !== 1'b0) begin failures++; $display("FAIL neg_early_dato got=%b exp=0", dato_nuevo); end
    send(-11'sd2); tick();
    checks++; if (temp_registrado !== -11'sd2) begin failures++; $display("FAIL neg_temp got=%0d exp=-2", temp_registrado); end
    checks++; if (contador_fuera_rango !== 3'd1) begin failures++; $display("FAIL neg_cnt got=%0d exp=1", contador_fuera_rango); end
    checks++; if (dato_nuevo !== 1'b1) begin failures++; $display("FAIL neg_dato got=%b exp=1", dato_nuevo); end
  endtask

  task automatic test_side_flip();
    int smp [7] = '{170, 170, 170, 170, 1023, 0, -400};
    int ea  [7] = '{41, 84, 127, 170, 383, 340, 198};
    int ec  [7] = '{2, 3, 4, 5, 1, 2, 0};
    logic signed [10:0] a;
    for (int i = 0; i < 7; i++) begin
      send(11'(smp[i]));
      tick();
      a = 11'(ea[i]);
      checks++; if (temp_registrado !== a) begin failures++; $display("FAIL flip_temp i=%0d got=%0d exp=%0d", i, temp_registrado, a); end
      checks++; if (contador_fuera_rango !== 3'(ec[i])) begin failures++; $display("FAIL flip_cnt i=%0d got=%0d exp=%0d", i, contador_fuera_rango, ec[i]); end
    end
  endtask

  task automatic test_timeout();
    temp_valid = 1'b0;
    repeat (19) tick();
    checks++; if (falla_sensor !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", falla_sensor); end
    tick();
    checks++; if (falla_sensor !== 1'b1) begin failures++; $display("FAIL timeout_falla got=%b exp=1", falla_sensor); end
    repeat (3) tick();
    checks++; if (temp_registrado !== 11'sd198 || contador_fuera_rango !== 3'd0 || dato_nuevo !== 1'b0) begin failures++; $display("FAIL timeout_hold temp=%0d cnt=%0d dato=%b exp temp=198 cnt=0 dato=0", temp_registrado, contador_fuera_rango, dato_nuevo); end
    checks++; if (temp_ready !== 1'b1 || falla_sensor !== 1'b1) begin failures++; $display("FAIL timeout_state ready=%b falla=%b exp ready=1 falla=1", temp_ready, falla_sensor); end
    send(11'sd230);
    checks++; if (falla_sensor !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", falla_sensor); end
    for (int i = 0; i < 2; i++) begin
      tick();
      send(11'sd230);
    end
    tick();
    checks++; if (dato_nuevo !== 1'b0 || temp_registrado !== 11'sd198) begin failures++; $display("FAIL refill_early dato=%b temp=%0d exp dato=0 temp=198", dato_nuevo, temp_registrado); end
    send(11'sd230);
    tick();
    checks++; if (temp_registrado !== 11'sd230 || dato_nuevo !== 1'b1) begin failures++; $display("FAIL refill_publish temp=%0d dato=%b exp temp=230 dato=1", temp_registrado, dato_nuevo); end
  endtask

  task automatic test_back_to_back();
    int smp [4] = '{240, 260, 200, 180};
    int ea  [4] = '{232, 240, 232, 220};
    int k;
    logic exp_rdy;
    logic signed [10:0] a;
    k = 0;
    temp_in    = 11'(smp[0]);
    temp_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_rdy = (i % 2 == 0);
      checks++; if (temp_ready !== exp_rdy) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", i, temp_ready, exp_rdy); end
      if (i > 0 && exp_rdy) begin
        a = 11'(ea[k - 1]);
        checks++; if (temp_registrado !== a || dato_nuevo !== 1'b1) begin failures++; $display("FAIL b2b_publish n=%0d temp=%0d dato=%b exp temp=%0d dato=1", k, temp_registrado, dato_nuevo, a); end
      end
      if (i == 8) break;
      if (temp_ready === 1'b1) begin
        tick();
        k++;
        if (k < 4) temp_in = 11'(smp[k]);
        else temp_valid = 1'b0;
      end else begin
        tick();
      end
    end
    temp_valid = 1'b0;
    checks++; if (k != 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", k); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_persist();
    test_reset_midstream();
    test_negatives();
    test_side_flip();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
